rr_mux_arb: RTL
===============

# rr_mux_arb

Two-requester round-robin arbiter that owns the select of a shared 2:1 multiplexer. Requesters A and B raise `req_a`/`req_b`. The block grants exactly one at a time, holds the grant while that request stays high, and drives the mux select so `y` carries the granted source. It sits directly in front of the existing 2:1 mux datapath and turns it from a free-running select into a shared resource.

## Interface
- `W`, default 1: data width of `a`, `b`, `y`.
- `MAX_BURST`, default 4: maximum consecutive grant cycles when the other side is waiting. Range 1..255. Used only with `ARB_BURST_LIMIT_EN`.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req_a`, input, 1: requester A wants the mux.
- `req_b`, input, 1: requester B wants the mux.
- `a`, input, W: data from requester A.
- `b`, input, W: data from requester B.
- `gnt_a`, output, 1: A owns the mux (registered).
- `gnt_b`, output, 1: B owns the mux (registered).
- `s`, output, 1: mux select (registered). 0 selects `a`, 1 selects `b`.
- `busy`, output, 1: either grant is active (registered).
- `y`, output, W: `s ? b : a` when `busy`, otherwise all zeros.

## Operation
- States: IDLE, GNT_A, GNT_B. Internal `last` records the last-served side.
- IDLE:
  - both requesting → grant the side opposite `last`;
  - only one requesting → grant it;
  - neither → stay in IDLE.
- GNT_A:
  - `req_a`=1 → stay;
  - `req_a`=0 and `req_b`=1 → go to GNT_B, with no idle bubble;
  - both 0 → go to IDLE.
- GNT_B: symmetric to GNT_A.
- `last` updates whenever a grant state is entered.
- Grants are one-hot or zero. `gnt_a & gnt_b` is never 1.
- `s` holds its previous value in IDLE. `y` is forced to 0 in IDLE.
- Reset values: state IDLE, `gnt_a`=0, `gnt_b`=0, `busy`=0, `s`=0, `y`=0, `last`=B (so A wins the first tie), burst counter 0.

## Timing
- Request sampled at edge N → grant, `s` and `busy` valid after edge N+1. Latency is 1 cycle.
- `y` follows `a`/`b` combinationally once `s`/`busy` are set.
- Release: a request dropped before edge N → grant deasserts after edge N.
- A→B handover: `gnt_a` falls and `gnt_b` rises after the same edge. `s` switches on that edge.
- Simultaneous first requests from IDLE → A is granted (`last`=B out of reset).
- `rst` high mid-grant → after that edge, all outputs are at reset values regardless of requests.
- Requests that pulse for less than one cycle and are low at the edge are ignored.

## Configuration
- Macro: `ARB_BURST_LIMIT_EN`.
- With the macro defined:
  - A burst counter of width `$clog2(MAX_BURST+1)` counts cycles in the current grant, starting at 1 on grant entry, and saturates.
  - When it reaches `MAX_BURST` while the other side requests, the grant switches to the other side on the next edge, even though the holder's request is still high.
  - The counter clears on every grant change and in IDLE.
- Without the macro: no counter exists, and a grant is held for as long as its request stays high (starvation is allowed).

## Structure
- Package `rr_mux_arb_pkg`:
  - typedef `arb_state_t` (IDLE=2'd0, GNT_A=2'd1, GNT_B=2'd2);
  - constant `SEL_A`=1'b0;
  - constant `SEL_B`=1'b1.
- Sub-module: the existing 2:1 mux, instantiated W times under a generate loop. The arbiter gates the mux output with `busy`.

## Test plan
- Reset then idle: `rst`=1 for 2 cycles, no requests → `gnt_a`=`gnt_b`=`busy`=`s`=0, `y`=0.
- Single requester: `req_a`=1, `a`=1, `b`=0 → one cycle later `gnt_a`=1, `s`=0, `y`=1. Drop `req_a` → `busy`=0 next cycle.
- Tie then alternation: `req_a`=`req_b`=1 pulsed for 1 cycle, then repeated → first grant A, second grant B.
- Handover: hold `req_b`=1 with `b`=1, `a`=0 while A releases → `gnt_b`=1, `s`=1, `y`=1 on the edge `gnt_a` falls, with no IDLE cycle.
- Reset mid-grant: while `gnt_b`=1, assert `rst` for 1 cycle → all outputs 0 after the edge. With both requests high after reset, A is granted.
- Burst limit (`ARB_BURST_LIMIT_EN`, `MAX_BURST`=4): `req_a` and `req_b` held high → `gnt_a` for exactly 4 cycles, then `gnt_b` for 4 cycles, alternating. Without the macro, `gnt_a` stays 1 indefinitely.

Source files
------------

// File: rtl/rr_mux_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_arb_pkg
// Description : Shared types and constants for the rr_mux_arb round-robin
//               mux arbiter: arbiter state encoding and mux select values.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_mux_arb_pkg;

    // Arbiter state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } arb_state_t;

    // Mux select values; also used to record the last-served side
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage : rr_mux_arb_pkg
`default_nettype wire

// File: rtl/rr_mux_arb_mux2.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_arb_mux2
// Description : Single-bit 2:1 multiplexer forming the shared datapath slice.
//               sel_i = SEL_A passes a_i, sel_i = SEL_B passes b_i.
// Ports       : sel_i - select
//               a_i   - input from requester A
//               b_i   - input from requester B
//               y_o   - selected output
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_arb_mux2
    import rr_mux_arb_pkg::*;
(
    input  logic sel_i,
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);

    assign y_o = (sel_i == SEL_B) ? b_i : a_i;

endmodule : rr_mux_arb_mux2
`default_nettype wire

// File: rtl/rr_mux_arb.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_arb
// Description : Two-requester round-robin arbiter owning the select of a
//               shared W-bit 2:1 mux. One grant at a time, held while its
//               request stays high; ties go to the side not served last.
//               Optional feature macro: ARB_BURST_LIMIT_EN - caps a grant at
//               MAX_BURST consecutive cycles while the other side waits.
// Parameters  : W         - data width of a, b, y
//               MAX_BURST - burst cap (1..255), used only with the macro
// Ports       : clk       - clock, rising edge
//               rst       - synchronous active-high reset
//               req_a     - requester A wants the mux
//               req_b     - requester B wants the mux
//               a, b      - requester data
//               gnt_a     - A owns the mux (registered)
//               gnt_b     - B owns the mux (registered)
//               s         - mux select (registered), 0 = a, 1 = b
//               busy      - a grant is active (registered)
//               y         - selected data while busy, zero otherwise
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_arb
    import rr_mux_arb_pkg::*;
#(
    parameter int W         = 1,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_a,
    input  logic         req_b,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gnt_a,
    output logic         gnt_b,
    output logic         s,
    output logic         busy,
    output logic [W-1:0] y
);

    arb_state_t   state_q, state_d;
    logic         last_q, last_d;   // last-served side (SEL_A / SEL_B)
    logic         s_q, s_d;
    logic         w_burst_expired;  // holder has used its full burst allowance
    logic [W-1:0] w_mux_y;

    // ------------------------------------------------------------------
    // Burst limiter
    // ------------------------------------------------------------------
`ifdef ARB_BURST_LIMIT_EN
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] C_MAX = CW'(MAX_BURST);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_d == IDLE) begin
            cnt_d = '0;
        end else if (state_d != state_q) begin
            // First cycle of a fresh grant counts as 1
            cnt_d = CW'(1);
        end else if (cnt_q != C_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign w_burst_expired = (cnt_q == C_MAX);
`else
    // Without the limiter a grant is held as long as its request stays high.
    // MAX_BURST only matters when the limiter is built; the empty labelled
    // block keeps the parameter referenced in this configuration.
    if (MAX_BURST < 1) begin : g_max_burst_unused
    end
    assign w_burst_expired = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        s_d     = s_q;

        case (state_q)
            IDLE: begin
                if (req_a && req_b) begin
                    state_d = (last_q == SEL_B) ? GNT_A : GNT_B;
                end else if (req_a) begin
                    state_d = GNT_A;
                end else if (req_b) begin
                    state_d = GNT_B;
                end
            end
            GNT_A: begin
                if (req_a) begin
                    if (req_b && w_burst_expired) begin
                        state_d = GNT_B;
                    end
                end else if (req_b) begin
                    state_d = GNT_B;   // direct handover, no idle bubble
                end else begin
                    state_d = IDLE;
                end
            end
            GNT_B: begin
                if (req_b) begin
                    if (req_a && w_burst_expired) begin
                        state_d = GNT_A;
                    end
                end else if (req_a) begin
                    state_d = GNT_A;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Select and last-served side move only on grant entry; in IDLE the
        // select keeps its previous value.
        if (state_d == GNT_A && state_q != GNT_A) begin
            last_d = SEL_A;
            s_d    = SEL_A;
        end else if (state_d == GNT_B && state_q != GNT_B) begin
            last_d = SEL_B;
            s_d    = SEL_B;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= SEL_B;   // A wins the first tie out of reset
            s_q     <= SEL_A;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            s_q     <= s_d;
        end
    end

    // Grant/busy decode straight from the state register
    assign gnt_a = (state_q == GNT_A);
    assign gnt_b = (state_q == GNT_B);
    assign busy  = (state_q != IDLE);
    assign s     = s_q;

    // ------------------------------------------------------------------
    // Shared datapath
    // ------------------------------------------------------------------
    for (genvar i = 0; i < W; i++) begin : g_mux
        rr_mux_arb_mux2 u_mux2 (
            .sel_i (s_q),
            .a_i   (a[i]),
            .b_i   (b[i]),
            .y_o   (w_mux_y[i])
        );
    end

    assign y = busy ? w_mux_y : '0;

endmodule : rr_mux_arb
`default_nettype wire
